lcd_hd44780_writer: RTL and testbench



---
 rtl/lcd_hd44780_writer_pkg.sv | 28 ++
 rtl/lcd_hd44780_writer_if.sv | 10 +
 rtl/lcd_hd44780_writer.sv | 160 ++++++++++++++++
 tb/tb_lcd_hd44780_writer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_hd44780_writer_pkg.sv
// Shared types and HD44780 command constants for the character-LCD byte writer.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        LOAD,
        SETUP,
        E_HIGH,
        HOLD,
        WAIT,
        IDLE
    } lcd_state_t;

    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] LINE2_ADDR    = 8'hC0;

    localparam int INIT_LEN = 6;

    // Clear (0x01) and Home (0x02/0x03) are the only commands needing the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
        return (rs == 1'b0) && (b[7:2] == 6'd0) && (b != 8'h00);
    endfunction

endpackage

// File: rtl/lcd_hd44780_writer_if.sv
// Valid/ready byte handshake between the text formatter and the LCD writer.
interface lcd_hd44780_writer_if;
    logic       iVALID;
    logic       iRS;
    logic [7:0] iBYTE;
    logic       oREADY;

    modport master (output iVALID, iRS, iBYTE, input oREADY);
    modport slave  (input iVALID, iRS, iBYTE, output oREADY);
endinterface

// File: rtl/lcd_hd44780_writer.sv
// Timed HD44780 8-bit byte writer: power-up delay, fixed init sequence, then
// handshaked command/character writes with setup, E pulse, hold and execution waits.
module lcd_hd44780_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EPW   = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    lcd_hd44780_writer_if.slave        up,
    output logic                       oINIT_DONE,
    output logic                       lcd_e,
    output logic                       lcd_rs,
    output logic                       lcd_rw,
    output logic [7:0]                 lcd_data
);

    localparam int unsigned T_ALL [0:5] = '{T_PWRUP, T_SETUP, T_EPW, T_HOLD, T_CMD, T_CLR};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_timing_check
            if (T_ALL[gi] == 0 || longint'(T_ALL[gi]) > (longint'(1) << CNT_W)) begin : g_bad
                $fatal(1, "lcd_hd44780_writer: timing parameter %0d is zero or exceeds CNT_W", gi);
            end
        end
    endgenerate

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return CMD_FUNC_8B2L;
            3'd3:             return CMD_DISP_ON;
            3'd4:             return CMD_ENTRY_INC;
            3'd5:             return CMD_CLEAR;
            default:          return 8'h00;
        endcase
    endfunction

    lcd_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic             rs_reg, rs_next;
    logic [7:0]       data_reg, data_next;
    logic             done_reg, done_next;
    logic             e_reg;
    logic             ready_reg;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg <= PWRUP;
            cnt_reg   <= '0;
            idx_reg   <= 3'd0;
            rs_reg    <= 1'b0;
            data_reg  <= 8'h00;
            done_reg  <= 1'b0;
            e_reg     <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            rs_reg    <= rs_next;
            data_reg  <= data_next;
            done_reg  <= done_next;
            e_reg     <= (state_next == E_HIGH);
            ready_reg <= (state_next == IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        rs_next    = rs_reg;
        data_next  = data_reg;
        done_next  = done_reg;
        case (state_reg)
            // Reset leaves the counter at zero, so power-up counts upward to its terminal value.
            PWRUP: begin
                if (cnt_reg == CNT_W'(T_PWRUP - 1)) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                    idx_next   = 3'd0;
                    rs_next    = 1'b0;
                    data_next  = init_byte(3'd0);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            LOAD: begin
                state_next = SETUP;
                cnt_next   = CNT_W'(T_SETUP - 1);
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = E_HIGH;
                    cnt_next   = CNT_W'(T_EPW - 1);
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            E_HIGH: begin
                if (cnt_reg == '0) begin
                    state_next = HOLD;
                    cnt_next   = CNT_W'(T_HOLD - 1);
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = WAIT;
                    cnt_next   = is_slow_cmd(rs_reg, data_reg) ? CNT_W'(T_CLR - 1) : CNT_W'(T_CMD - 1);
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (idx_reg < 3'(INIT_LEN - 1)) begin
                    state_next = LOAD;
                    idx_next   = idx_reg + 3'd1;
                    rs_next    = 1'b0;
                    data_next  = init_byte(idx_reg + 3'd1);
                end else begin
                    // Index parks at INIT_LEN so later user writes also return straight to IDLE.
                    state_next = IDLE;
                    idx_next   = 3'(INIT_LEN);
                    done_next  = 1'b1;
                end
            end
            IDLE: begin
                if (up.iVALID) begin
                    state_next = SETUP;
                    cnt_next   = CNT_W'(T_SETUP - 1);
                    rs_next    = up.iRS;
                    data_next  = up.iBYTE;
                end
            end
            default: begin
                state_next = PWRUP;
                cnt_next   = '0;
            end
        endcase
    end

    assign up.oREADY  = ready_reg;
    assign oINIT_DONE = done_reg;
    assign lcd_e      = e_reg;
    assign lcd_rs     = rs_reg;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = data_reg;

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Randomised self-checking bench for the HD44780 byte writer with a cycle-level timing model.
module tb_lcd_hd44780_writer;
    import lcd_pkg::*;

    localparam int T_PWRUP = 100;
    localparam int T_SETUP = 2;
    localparam int T_EPW   = 4;
    localparam int T_HOLD  = 2;
    localparam int T_CMD   = 20;
    localparam int T_CLR   = 50;

    localparam logic [7:0] INIT_SEQ [0:5] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    localparam logic [7:0] SPECIAL  [0:6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hC0, 8'hFF};

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       oINIT_DONE;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    lcd_hd44780_writer_if up_if ();

    lcd_hd44780_writer #(
        .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EPW(T_EPW),
        .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLR(T_CLR), .CNT_W(20)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .up        (up_if),
        .oINIT_DONE(oINIT_DONE),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int         rise;
        int         fall;
        logic       rs;
        logic [7:0] d;
    } pulse_t;

    pulse_t pulses[$];
    int     unstable = 0;
    int     done_rise = -1;
    logic   prev_e = 1'b0;
    logic   prev_done = 1'b0;

    // Records every E pulse and flags any bus change while E is high.
    always begin
        pulse_t p;
        @(posedge iCLK);
        #1;
        if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
            p.rise = cyc; p.fall = -1; p.rs = lcd_rs; p.d = lcd_data;
            pulses.push_back(p);
        end else if (lcd_e === 1'b1 && pulses.size() > 0) begin
            if (lcd_rs !== pulses[pulses.size()-1].rs || lcd_data !== pulses[pulses.size()-1].d)
                unstable++;
        end
        if (lcd_e !== 1'b1 && prev_e === 1'b1 && pulses.size() > 0)
            pulses[pulses.size()-1].fall = cyc;
        if (oINIT_DONE === 1'b1 && prev_done !== 1'b1)
            done_rise = cyc;
        prev_e    = lcd_e;
        prev_done = oINIT_DONE;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_wait(input logic rs, input logic [7:0] b);
        return (rs == 1'b0 && b >= 8'h01 && b <= 8'h03) ? T_CLR : T_CMD;
    endfunction

    task automatic wait_ready(input int limit, input bit noise, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge iCLK);
            if (up_if.oREADY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (noise) begin
                up_if.iVALID = 1'($urandom_range(0, 1));
                up_if.iRS    = 1'($urandom_range(0, 1));
                up_if.iBYTE  = 8'($urandom);
            end
        end
    endtask

    // Expects the full init sequence after a reset release at cycle rel.
    task automatic check_init(input int rel, input string tag);
        bit ok;
        wait_ready(T_PWRUP + 6 * (T_CLR + 20) + 100, 1'b0, ok);
        chk({tag, "_timeout"}, 32'(ok), 32'd1);
        chk({tag, "_pulse_count"}, pulses.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < pulses.size()) begin
                chk({tag, "_data"}, 32'(pulses[i].d), 32'(INIT_SEQ[i]));
                chk({tag, "_rs"}, 32'(pulses[i].rs), 32'd0);
                chk({tag, "_width"}, pulses[i].fall - pulses[i].rise, T_EPW);
                if (i < 5 && i + 1 < pulses.size())
                    chk({tag, "_gap"}, pulses[i+1].rise - pulses[i].fall, T_HOLD + T_CMD + 1 + T_SETUP);
            end
        end
        if (pulses.size() > 0)
            chk({tag, "_first_rise"}, pulses[0].rise, rel + T_PWRUP + 1 + T_SETUP);
        if (pulses.size() == 6)
            chk({tag, "_clear_wait"}, cyc - pulses[5].fall, T_HOLD + T_CLR);
        chk({tag, "_done"}, 32'(oINIT_DONE), 32'd1);
        chk({tag, "_done_with_ready"}, done_rise, cyc);
        $display("init %s: pulses=%0d ready_at=%0d", tag, pulses.size(), cyc);
    endtask

    // Called at a negedge with oREADY high; returns with oREADY high again.
    task automatic do_xfer(input logic rs, input logic [7:0] b, input int gap, output int t_acc);
        bit ok;
        int exp_ready;
        up_if.iVALID = 1'b0;
        repeat (gap) @(negedge iCLK);
        up_if.iVALID = 1'b1;
        up_if.iRS    = rs;
        up_if.iBYTE  = b;
        t_acc = cyc;
        pulses.delete();
        @(negedge iCLK);
        up_if.iVALID = 1'b0;
        up_if.iRS    = ~rs;
        up_if.iBYTE  = ~b;
        chk("latch_rs", 32'(lcd_rs), 32'(rs));
        chk("latch_data", 32'(lcd_data), 32'(b));
        chk("busy_ready", 32'(up_if.oREADY), 32'd0);
        wait_ready(T_CLR + 50, 1'b1, ok);
        chk("xfer_timeout", 32'(ok), 32'd1);
        exp_ready = t_acc + 1 + T_SETUP + T_EPW + T_HOLD + exp_wait(rs, b);
        chk("ready_return", cyc, exp_ready);
        chk("pulse_count", pulses.size(), 1);
        if (pulses.size() > 0) begin
            chk("e_rise", pulses[0].rise, t_acc + 1 + T_SETUP);
            chk("e_fall", pulses[0].fall, t_acc + 1 + T_SETUP + T_EPW);
            chk("pulse_rs", 32'(pulses[0].rs), 32'(rs));
            chk("pulse_data", 32'(pulses[0].d), 32'(b));
        end
        chk("idle_hold_data", 32'(lcd_data), 32'(b));
        chk("rw_low", 32'(lcd_rw), 32'd0);
        $display("xfer rs=%0d byte=%02h accept=%0d ready=%0d", rs, b, t_acc, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rel;
        int   t0, t1;
        bit   ok;
        logic rs;
        logic [7:0] b;

        up_if.iVALID = 1'b0;
        up_if.iRS    = 1'b0;
        up_if.iBYTE  = 8'h00;

        repeat (3) @(negedge iCLK);
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_rw", 32'(lcd_rw), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'd0);
        chk("rst_ready", 32'(up_if.oREADY), 32'd0);
        chk("rst_done", 32'(oINIT_DONE), 32'd0);

        pulses.delete();
        rel  = cyc;
        iRST = 1'b0;
        check_init(rel, "init");

        // Clear then data, then line-2 address, back to back.
        do_xfer(1'b0, CMD_CLEAR, 0, t0);
        do_xfer(1'b1, 8'h31, 0, t1);
        chk("clear_spacing", t1 - t0, 59);
        do_xfer(1'b0, LINE2_ADDR, 0, t0);
        do_xfer(1'b1, 8'h41, 0, t1);
        chk("cmd_spacing", t1 - t0, 29);

        for (int n = 0; n < 12; n++) begin
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) b = SPECIAL[$urandom_range(0, 6)];
            else                           b = 8'($urandom);
            do_xfer(rs, b, $urandom_range(0, 2), t0);
        end
        chk("bus_stable_during_e", unstable, 0);

        // Reset while E is high.
        up_if.iVALID = 1'b1;
        up_if.iRS    = 1'b1;
        up_if.iBYTE  = 8'h77;
        @(negedge iCLK);
        up_if.iVALID = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            if (lcd_e === 1'b1) begin ok = 1'b1; break; end
        end
        chk("reach_e_high", 32'(ok), 32'd1);
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        chk("midrst_e", 32'(lcd_e), 32'd0);
        chk("midrst_data", 32'(lcd_data), 32'd0);
        chk("midrst_rs", 32'(lcd_rs), 32'd0);
        chk("midrst_done", 32'(oINIT_DONE), 32'd0);
        chk("midrst_ready", 32'(up_if.oREADY), 32'd0);
        @(negedge iCLK);

        // iVALID held high through the whole re-init.
        up_if.iVALID = 1'b1;
        up_if.iRS    = 1'b1;
        up_if.iBYTE  = 8'h5A;
        pulses.delete();
        done_rise = -1;
        rel  = cyc;
        iRST = 1'b0;
        check_init(rel, "reinit");
        t0 = cyc;
        @(negedge iCLK);
        up_if.iVALID = 1'b0;
        chk("held_accept_rs", 32'(lcd_rs), 32'd1);
        chk("held_accept_data", 32'(lcd_data), 32'h5A);
        chk("held_accept_busy", 32'(up_if.oREADY), 32'd0);
        wait_ready(T_CLR + 50, 1'b0, ok);
        chk("held_timeout", 32'(ok), 32'd1);
        chk("held_ready_return", cyc, t0 + 1 + T_SETUP + T_EPW + T_HOLD + T_CMD);
        chk("held_pulse_count", pulses.size(), 7);
        if (pulses.size() == 7)
            chk("held_pulse_data", 32'(pulses[6].d), 32'h5A);
        $display("xfer rs=1 byte=5a accept=%0d ready=%0d", t0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
